// File: rtl/soc_system_onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip memory with
// fixed 1-cycle read latency. Grant is combinational; read returns are routed by a registered owner tag.
module soc_system_onchip_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata
);
    localparam int BE_W = DATA_W / 8;

    logic [1:0]        req;
    logic [1:0]        wr;
    logic [1:0]        gnt;
    logic              winner;
    logic [1:0]        wait_vec;
    logic [1:0]        rdv_vec;
    logic              last_gnt_reg;
    logic              rd_valid_reg;
    logic              rd_owner_reg;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [BE_W-1:0]   be_arr    [2];
    logic [DATA_W-1:0] wdata_arr [2];

    assign wr           = {m1_write, m0_write};
    assign req          = {m1_read | m1_write, m0_read | m0_write};
    assign addr_arr[0]  = m0_address;
    assign addr_arr[1]  = m1_address;
    assign be_arr[0]    = m0_byteenable;
    assign be_arr[1]    = m1_byteenable;
    assign wdata_arr[0] = m0_writedata;
    assign wdata_arr[1] = m1_writedata;

    // Under contention the requester that did not win last time takes the slot.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req == 2'b11) begin
                gnt = last_gnt_reg ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    assign winner         = gnt[1];
    assign mem_chipselect = |gnt;
    assign mem_write      = (|gnt) & wr[winner];
    assign mem_address    = addr_arr[winner];
    assign mem_byteenable = be_arr[winner];
    assign mem_writedata  = wdata_arr[winner];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign wait_vec[gi] = req[gi] & ~gnt[gi];
            assign rdv_vec[gi]  = rd_valid_reg & (rd_owner_reg == gi[0]);
        end
    endgenerate

    assign m0_waitrequest   = wait_vec[0];
    assign m1_waitrequest   = wait_vec[1];
    assign m0_readdatavalid = rdv_vec[0];
    assign m1_readdatavalid = rdv_vec[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    // A write with read also asserted is a write, so it never schedules a return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_reg <= 1'b1;
            rd_valid_reg <= 1'b0;
            rd_owner_reg <= 1'b0;
        end else begin
            if (|gnt) begin
                last_gnt_reg <= winner;
            end
            rd_valid_reg <= (|gnt) & ~wr[winner];
            rd_owner_reg <= winner;
        end
    end
endmodule

// File: tb/tb_soc_system_onchip_mem_arbiter.sv
// Bench for the two-port memory arbiter: a request-level model with a read-return
// queue is compared every cycle, plus directed literal expectations per scenario.
module tb_soc_system_onchip_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_readdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_system_onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(rst),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory behind the arbiter: command sampled mid-cycle, applied at the edge.
    logic [31:0] mem [1024];
    logic        cmd_cs, cmd_we;
    logic [9:0]  cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | i;
        cmd_cs = 1'b0;
    end

    always @(negedge clk) begin
        cmd_cs    = mem_chipselect;
        cmd_we    = mem_write;
        cmd_addr  = mem_address;
        cmd_be    = mem_byteenable;
        cmd_wdata = mem_writedata;
    end

    always @(posedge clk) begin
        if (cmd_cs && cmd_we) begin
            for (int b = 0; b < 4; b++)
                if (cmd_be[b]) mem[cmd_addr][8*b +: 8] = cmd_wdata[8*b +: 8];
        end else if (cmd_cs) begin
            mem_readdata <= mem[cmd_addr];
        end
    end

    // Behavioural model: who wins, what reaches memory, and which read returns are due.
    typedef struct {
        int          who;
        logic [31:0] data;
        int          due;
    } rd_t;
    rd_t exp_q[$];
    int  cyc = 0;
    int  last = 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last = 1;
            chk("rst_cs", mem_chipselect, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_rdv0", m0_readdatavalid, 0);
            chk("rst_rdv1", m1_readdatavalid, 0);
        end else begin
            bit r0, r1, ev0, ev1, is_wr;
            int w;
            logic [31:0] ed;
            logic [9:0]  ea;
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            w = -1;
            if (r0 && r1) w = (last == 0) ? 1 : 0;
            else if (r0) w = 0;
            else if (r1) w = 1;
            chk("m_wait0", m0_waitrequest, (r0 && w != 0) ? 1 : 0);
            chk("m_wait1", m1_waitrequest, (r1 && w != 1) ? 1 : 0);
            chk("m_cs", mem_chipselect, (w >= 0) ? 1 : 0);
            ev0 = 0; ev1 = 0; ed = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                if (exp_q[0].who == 0) ev0 = 1; else ev1 = 1;
                ed = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            chk("m_rdv0", m0_readdatavalid, ev0);
            chk("m_rdv1", m1_readdatavalid, ev1);
            if (ev0) chk("m_rdata0", m0_readdata, ed);
            if (ev1) chk("m_rdata1", m1_readdata, ed);
            if (w >= 0) begin
                is_wr = (w == 0) ? m0_write : m1_write;
                ea    = (w == 0) ? m0_address : m1_address;
                chk("m_mem_write", mem_write, is_wr);
                chk("m_mem_addr", mem_address, ea);
                chk("m_mem_be", mem_byteenable, (w == 0) ? m0_byteenable : m1_byteenable);
                if (is_wr) chk("m_mem_wdata", mem_writedata, (w == 0) ? m0_writedata : m1_writedata);
                else exp_q.push_back('{who: w, data: mem[ea], due: cyc + 1});
                $display("txn cyc=%0d m%0d %s addr=%03h", cyc, w, is_wr ? "write" : "read", ea);
                last = w;
            end else begin
                chk("m_mem_write_idle", mem_write, 0);
            end
        end
        cyc++;
    end

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        step(); rst = 1; idle();
        step(); rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, k1;
        rst = 1; idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cs", mem_chipselect, 0);
        chk("reset_rdv0", m0_readdatavalid, 0);
        step(); rst = 0;

        // single m0 read right after reset
        m0_read = 1; m0_address = 10'h005;
        @(negedge clk);
        chk("r24_wait0", m0_waitrequest, 0);
        chk("r24_addr", mem_address, 10'h005);
        chk("r24_cs", mem_chipselect, 1);
        step(); idle();
        @(negedge clk);
        chk("r24_rdv0", m0_readdatavalid, 1);
        chk("r24_rdata", m0_readdata, 32'hC0DE0005);
        chk("r24_rdv1", m1_readdatavalid, 0);

        // both write continuously: strict alternation starting with m0
        do_reset();
        k0 = 0; k1 = 0;
        for (int c = 0; c < 8; c++) begin
            m0_write = 1; m0_address = 10'h100 + k0[9:0]; m0_writedata = 32'hAAAA0000 + k0;
            m1_write = 1; m1_address = 10'h200 + k1[9:0]; m1_writedata = 32'h55550000 + k1;
            @(negedge clk);
            chk("r25_wait0", m0_waitrequest, c % 2);
            chk("r25_wait1", m1_waitrequest, 1 - (c % 2));
            chk("r25_wdata", mem_writedata, (c % 2 == 0) ? 32'hAAAA0000 + c / 2 : 32'h55550000 + c / 2);
            if (!m0_waitrequest) k0++;
            if (!m1_waitrequest) k1++;
            step();
        end
        idle();
        chk("r25_m0_count", k0, 4);
        chk("r25_m1_count", k1, 4);

        // m0 read vs m1 write in the same cycle
        do_reset();
        m0_read = 1; m0_address = 10'h020;
        m1_write = 1; m1_address = 10'h021; m1_writedata = 32'hBEEF0001;
        @(negedge clk);
        chk("r26_wait0", m0_waitrequest, 0);
        chk("r26_wait1", m1_waitrequest, 1);
        step(); m0_read = 0;
        @(negedge clk);
        chk("r26_wait1b", m1_waitrequest, 0);
        chk("r26_mem_write", mem_write, 1);
        chk("r26_rdv0", m0_readdatavalid, 1);
        chk("r26_rdata", m0_readdata, 32'hC0DE0020);
        step(); idle();

        // m1 burst of reads at the top of the address space
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m1_read = 1; m1_address = 10'h3FC + i[9:0];
            @(negedge clk);
            chk("r27_wait1", m1_waitrequest, 0);
            chk("r27_addr", mem_address, 10'h3FC + i);
            if (i > 0) begin
                chk("r27_rdv1", m1_readdatavalid, 1);
                chk("r27_rdata", m1_readdata, 32'hC0DE03FC + i - 1);
            end
            step();
        end
        idle();
        @(negedge clk);
        chk("r27_idle_cs", mem_chipselect, 0);
        chk("r27_last_rdv1", m1_readdatavalid, 1);
        chk("r27_last_rdata", m1_readdata, 32'hC0DE03FF);
        step();
        @(negedge clk);
        chk("r27_done_rdv1", m1_readdatavalid, 0);

        // reset arriving mid-cycle after an m0 read is accepted
        do_reset();
        m0_read = 1; m0_address = 10'h007;
        #1;
        chk("r28_wait0", m0_waitrequest, 0);
        chk("r28_cs", mem_chipselect, 1);
        #1 rst = 1;
        @(negedge clk);
        chk("r28_cs_rst", mem_chipselect, 0);
        step(); idle();
        @(negedge clk);
        chk("r28_rdv0", m0_readdatavalid, 0);
        step(); rst = 0;
        m0_read = 1; m0_address = 10'h008;
        m1_read = 1; m1_address = 10'h009;
        @(negedge clk);
        chk("r28_first_wait0", m0_waitrequest, 0);
        chk("r28_first_wait1", m1_waitrequest, 1);
        step(); m0_read = 0;
        @(negedge clk);
        chk("r28_second_wait1", m1_waitrequest, 0);
        chk("r28_rdv0_after", m0_readdatavalid, 1);
        step(); idle();
        @(negedge clk);
        chk("r28_rdv1_after", m1_readdatavalid, 1);
        chk("r28_rdata1", m1_readdata, 32'hC0DE0009);

        // read+write together is a write; then a byte-lane write and a read-back
        step();
        m0_read = 1; m0_write = 1; m0_address = 10'h010; m0_writedata = 32'h12345678;
        @(negedge clk);
        chk("r29_mem_write", mem_write, 1);
        chk("r29_wdata", mem_writedata, 32'h12345678);
        step(); idle();
        m1_write = 1; m1_address = 10'h010; m1_byteenable = 4'b0001; m1_writedata = 32'h000000AB;
        @(negedge clk);
        chk("r29_no_rdv0", m0_readdatavalid, 0);
        chk("r29_be", mem_byteenable, 4'b0001);
        step(); idle();
        m0_read = 1; m0_address = 10'h010;
        step(); idle();
        @(negedge clk);
        chk("r29_readback", m0_readdata, 32'h123456AB);
        chk("r29_readback_v", m0_readdatavalid, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/soc_system_onchip_mem_arbiter.md
SOC_SYSTEM_ONCHIP_MEM_ARBITER -- requirements
Module: soc_system_onchip_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the word address width of the shared memory port.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width; the byteenable width is DATA_W/8.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset: clk  input  1  clock for all logic; reset  input  1  asynchronous active-high reset.
REQ-004 Requester ports (n = 0, 1), inputs: mN_address (ADDR_W), mN_byteenable (DATA_W/8), mN_read (1), mN_write (1), mN_writedata (DATA_W).
REQ-005 Requester ports (n = 0, 1), outputs: mN_waitrequest (1, transfer not accepted this cycle), mN_readdata (DATA_W), mN_readdatavalid (1, read data valid).
REQ-006 Memory port, outputs: mem_address (ADDR_W), mem_byteenable (DATA_W/8), mem_chipselect (1), mem_write (1), mem_writedata (DATA_W).
REQ-007 Memory port, input: mem_readdata (DATA_W), valid exactly 1 clk after the read was issued.

Function
REQ-008 A requester SHALL be requesting when mN_read or mN_write is 1; mN_write=1 with mN_read=1 SHALL be treated as a write.
REQ-009 At most one transfer SHALL be issued to the memory port per cycle; grant is combinational from the current requests and the registered pointer last_gnt.
REQ-010 Only one requester: it SHALL be granted; both requesting: the one not equal to last_gnt SHALL be granted (round-robin).
REQ-011 The granted requester SHALL see mN_waitrequest=0 in the same cycle; a requesting, non-granted requester SHALL see mN_waitrequest=1.
REQ-012 A non-requesting requester SHALL see mN_waitrequest=0.
REQ-013 On a grant, mem_chipselect SHALL be 1 and mem_address, mem_byteenable, mem_writedata, mem_write SHALL equal the winner's inputs in that cycle; with no grant, mem_chipselect=0 and mem_write=0.
REQ-014 last_gnt SHALL update to the winner at the clk edge ending a granted cycle and hold otherwise.
REQ-015 An accepted read SHALL produce mN_readdatavalid=1 for exactly one cycle, 1 clk after acceptance, with mN_readdata=mem_readdata; latency is fixed at 1.
REQ-016 Read routing SHALL use a registered valid bit plus owner tag captured at acceptance; the other requester's readdatavalid SHALL remain 0.
REQ-017 Back-to-back reads SHALL be accepted every cycle with no bubbles; reads and writes may interleave cycle-by-cycle.
REQ-018 Accepted writes SHALL produce no readdatavalid.
REQ-019 mN_readdata MAY carry any value when mN_readdatavalid=0; implementations SHALL drive mem_readdata onto both.
REQ-020 mem_address SHALL pass the address unmodified (no wrap, no offset).

Reset
REQ-021 While reset=1: last_gnt=1 (so requester 0 wins the first contention), read-pending valid=0, mem_chipselect=0, mem_write=0, mN_readdatavalid=0.
REQ-022 An assertion of reset SHALL take effect immediately; a read accepted in the cycle reset asserts SHALL NOT produce readdatavalid.
REQ-023 The first transfer after reset deassertion SHALL be accepted in the first clk cycle after deassertion.

Verification
REQ-024 Reset, then m0 read addr 0x005 alone -> m0_waitrequest=0 the same cycle, mem_address=0x005, mem_chipselect=1; next cycle m0_readdatavalid=1 with mem_readdata value, m1_readdatavalid=0.
REQ-025 Both write continuously, m0 data 0xAAAA0000+k, m1 data 0x55550000+k -> grants alternate m0,m1,m0,... starting with m0; each waits exactly every other cycle; 8 cycles = 4 writes each.
REQ-026 m0 read and m1 write same cycle after reset -> m0 granted, m1_waitrequest=1; next cycle m1 granted with mem_write=1; m0_readdatavalid=1 in that cycle.
REQ-027 m1 reads 4 consecutive addresses 0x3FC-0x3FF, m0 idle -> 4 accepts in 4 cycles, 4 readdatavalid pulses 1 cycle later, no bubbles, mem_address 0x3FF then idle.
REQ-028 Reset asserted mid-cycle after an accepted m0 read -> m0_readdatavalid stays 0; after deassertion, simultaneous requests -> m0 granted first.
REQ-029 m0 read=1 and write=1 together with writedata 0x12345678 -> mem_write=1, mem_writedata=0x12345678, no readdatavalid follows.
